// File: rtl/aes_pkg.sv
// Shared AES-128 key-schedule definitions: sizes, rcon table, S-box and the
// inverse rcon step used when walking the schedule backwards.
package aes_pkg;

    localparam int unsigned AES_NK         = 4;
    localparam int unsigned NUM_ROUNDS_128 = 10;

    typedef logic [32*AES_NK-1:0] aes_key_t;
    typedef logic [31:0]          aes_word_t;

    typedef enum logic {
        KS_IDLE,
        KS_RUN
    } ks_state_t;

    localparam logic [7:0] RCON [NUM_ROUNDS_128] = '{
        8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
    };

    localparam logic [7:0] SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    function automatic logic [7:0] sbox(input logic [7:0] x);
        return SBOX[x];
    endfunction

    // Undo one rcon doubling: divide by x in GF(2^8) modulo 0x11b.
    function automatic logic [7:0] inv_xtime(input logic [7:0] x);
        logic [8:0] t;
        t = x[0] ? ({1'b0, x} ^ 9'h11b) : {1'b0, x};
        return t[8:1];
    endfunction

endpackage

// File: rtl/sub_word.sv
// SubWord: byte-wise AES S-box substitution of a 32-bit word.
module sub_word
    import aes_pkg::*;
(
    input  logic [31:0] i_word,
    output logic [31:0] o_word
);

    // One S-box lookup per byte lane
    always_comb begin
        o_word = '0;
        for (int unsigned i = 0; i < 4; i++) begin
            o_word[8*i +: 8] = sbox(i_word[8*i +: 8]);
        end
    end

endmodule

// File: rtl/inv_key_schedule.sv
// Inverse AES-128 key expansion: takes the last round key and walks the
// schedule back to round 0, one key per valid/ready handshake.
module inv_key_schedule
    import aes_pkg::*;
#(
    parameter int unsigned NUM_ROUNDS = NUM_ROUNDS_128,
    parameter logic [7:0]  LAST_RCON  = RCON[NUM_ROUNDS_128-1]
)(
    input  logic         clk,
    input  logic         rst,
    input  logic         loadValid,
    output logic         loadReady,
    input  logic [127:0] keyIn,
    output logic [127:0] keyOut,
    output logic [3:0]   keyRound,
    output logic         keyValid,
    input  logic         keyReady,
    output logic         busy
);

    ks_state_t    r_state;
    ks_state_t    w_state_nxt;
    logic [127:0] r_key;
    logic [3:0]   r_round;
    logic [7:0]   r_rcon;
    logic         w_load;
    logic         w_advance;

    logic [31:0]  w_w0, w_w1, w_w2, w_w3;
    logic [31:0]  w_p0, w_p1, w_p2, w_p3;
    logic [31:0]  w_sub;

    assign w_w0 = r_key[127:96];
    assign w_w1 = r_key[95:64];
    assign w_w2 = r_key[63:32];
    assign w_w3 = r_key[31:0];

    // Previous round key: the last three columns fall out of XORs of
    // neighbours; column 0 needs SubWord(RotWord) of the recovered column 3.
    assign w_p3 = w_w3 ^ w_w2;
    assign w_p2 = w_w2 ^ w_w1;
    assign w_p1 = w_w1 ^ w_w0;
    assign w_p0 = w_w0 ^ w_sub ^ {r_rcon, 24'h0};

    sub_word u_sub_word (
        .i_word ({w_p3[23:0], w_p3[31:24]}),
        .o_word (w_sub)
    );

    // Next-state and handshake decode
    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_advance   = 1'b0;
        case (r_state)
            KS_IDLE: begin
                if (loadValid) begin
                    w_load      = 1'b1;
                    w_state_nxt = KS_RUN;
                end
            end
            KS_RUN: begin
                if (keyReady) begin
                    if (r_round != '0) begin
                        w_advance = 1'b1;
                    end else begin
                        w_state_nxt = KS_IDLE;
                    end
                end
            end
            default: w_state_nxt = KS_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= KS_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Key, round index and rcon registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_key   <= '0;
            r_round <= '0;
            r_rcon  <= '0;
        end else if (w_load) begin
            r_key   <= keyIn;
            r_round <= 4'(NUM_ROUNDS);
            r_rcon  <= LAST_RCON;
        end else if (w_advance) begin
            r_key   <= {w_p0, w_p1, w_p2, w_p3};
            r_round <= r_round - 4'd1;
            r_rcon  <= inv_xtime(r_rcon);
        end
    end

    assign keyOut    = r_key;
    assign keyRound  = r_round;
    assign keyValid  = (r_state == KS_RUN);
    assign busy      = (r_state == KS_RUN);
    assign loadReady = (r_state == KS_IDLE);

endmodule

// File: tb/tb_inv_key_schedule.sv
// Self-checking bench for inv_key_schedule against a forward AES-128 key
// expansion model whose S-box is derived from GF(2^8) arithmetic.
module tb_inv_key_schedule;

    logic         clk;
    logic         rst;
    logic         loadValid;
    logic         loadReady;
    logic [127:0] keyIn;
    logic [127:0] keyOut;
    logic [3:0]   keyRound;
    logic         keyValid;
    logic         keyReady;
    logic         busy;

    int n_tests;
    int n_fail;

    logic [7:0]   tb_sbox [256];
    logic [127:0] exp_rk  [0:10];

    localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] FIPS_RK10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    localparam logic [127:0] FIPS_RK9  = 128'hac7766f319fadc2128d12941575c006e;
    localparam logic [127:0] FIPS_RK1  = 128'ha0fafe1788542cb123a339392a6c7605;

    inv_key_schedule #(
        .NUM_ROUNDS (10),
        .LAST_RCON  (8'h36)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .loadValid (loadValid),
        .loadReady (loadReady),
        .keyIn     (keyIn),
        .keyOut    (keyOut),
        .keyRound  (keyRound),
        .keyValid  (keyValid),
        .keyReady  (keyReady),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [7:0] xtime(input logic [7:0] x);
        return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
        return 8'((v << n) | (v >> (8 - n)));
    endfunction

    // S-box = affine transform of the multiplicative inverse
    task automatic build_sbox();
        logic [7:0] inv;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++) begin
                if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            end
            tb_sbox[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
        end
    endtask

    // Forward AES-128 key expansion into exp_rk[0..10]
    task automatic expand(input logic [127:0] key);
        logic [31:0] w [44];
        logic [31:0] t;
        logic [7:0]  rc;
        rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = key[127 - 32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {t[23:0], t[31:24]};
                t = {tb_sbox[t[31:24]], tb_sbox[t[23:16]], tb_sbox[t[15:8]], tb_sbox[t[7:0]]};
                t = t ^ {rc, 24'h0};
                rc = xtime(rc);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int r = 0; r < 11; r++) exp_rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    task automatic do_load(input logic [127:0] k);
        @(negedge clk);
        keyIn     = k;
        loadValid = 1'b1;
        @(negedge clk);
        loadValid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        @(negedge clk);
        n_tests++;
        if ({keyValid, busy, loadReady} !== 3'b001 || keyOut !== '0 || keyRound !== 4'd0) begin
            n_fail++;
            $display("FAIL reset: valid/busy/ready=%b keyOut=%h keyRound=%0d, required 001/0/0",
                     {keyValid, busy, loadReady}, keyOut, keyRound);
        end
        rst = 1'b0;
        @(negedge clk);
        n_tests++;
        if (keyValid !== 1'b0 || loadReady !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_idle: keyValid=%b loadReady=%b, required 0/1", keyValid, loadReady);
        end
    endtask

    task automatic test_fips_walk();
        expand(FIPS_KEY);
        keyReady = 1'b1;
        do_load(FIPS_RK10);
        for (int r = 10; r >= 0; r--) begin
            n_tests++;
            if (keyValid !== 1'b1 || keyRound !== 4'(r) || keyOut !== exp_rk[r]) begin
                n_fail++;
                $display("FAIL walk_r%0d: valid=%b round=%0d key=%h, required 1/%0d/%h",
                         r, keyValid, keyRound, keyOut, r, exp_rk[r]);
            end
            if (r == 10 || r == 9 || r == 1 || r == 0) begin
                n_tests++;
                if (keyOut !== (r == 10 ? FIPS_RK10 : r == 9 ? FIPS_RK9 : r == 1 ? FIPS_RK1 : FIPS_KEY)) begin
                    n_fail++;
                    $display("FAIL walk_fips_r%0d: key=%h", r, keyOut);
                end
            end
            @(negedge clk);
        end
        n_tests++;
        if (busy !== 1'b0 || keyValid !== 1'b0) begin
            n_fail++;
            $display("FAIL walk_done: busy=%b keyValid=%b, required 0/0", busy, keyValid);
        end
    endtask

    task automatic test_backpressure();
        logic [127:0] got_k [$];
        logic [3:0]   got_r [$];
        logic [127:0] prev_key;
        logic [3:0]   prev_round;
        logic         have_prev;
        logic         prev_ready;
        logic         rdy;
        expand(FIPS_KEY);
        keyReady   = 1'b0;
        have_prev  = 1'b0;
        prev_ready = 1'b0;
        prev_key   = '0;
        prev_round = '0;
        do_load(FIPS_RK10);
        for (int cyc = 0; cyc < 300 && got_k.size() < 11; cyc++) begin
            if (keyValid) begin
                if (have_prev && !prev_ready) begin
                    n_tests++;
                    if (keyOut !== prev_key || keyRound !== prev_round) begin
                        n_fail++;
                        $display("FAIL bp_stable: key=%h round=%0d, required %h/%0d",
                                 keyOut, keyRound, prev_key, prev_round);
                    end
                end
                prev_key   = keyOut;
                prev_round = keyRound;
                have_prev  = 1'b1;
                rdy        = 1'($urandom_range(0, 1));
                keyReady   = rdy;
                prev_ready = rdy;
                if (rdy) begin
                    got_k.push_back(keyOut);
                    got_r.push_back(keyRound);
                end
            end else begin
                keyReady  = 1'b0;
                have_prev = 1'b0;
            end
            @(negedge clk);
        end
        keyReady = 1'b0;
        n_tests++;
        if (got_k.size() != 11) begin
            n_fail++;
            $display("FAIL bp_count: %0d keys accepted, required 11", got_k.size());
        end
        for (int i = 0; i < got_k.size() && i < 11; i++) begin
            n_tests++;
            if (got_r[i] !== 4'(10 - i) || got_k[i] !== exp_rk[10 - i]) begin
                n_fail++;
                $display("FAIL bp_seq%0d: round=%0d key=%h, required %0d/%h",
                         i, got_r[i], got_k[i], 10 - i, exp_rk[10 - i]);
            end
        end
        n_tests++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_done: busy=%b, required 0", busy);
        end
    endtask

    task automatic test_load_while_busy();
        expand(FIPS_KEY);
        keyReady = 1'b1;
        do_load(FIPS_RK10);
        keyIn     = '1;
        loadValid = 1'b1;
        for (int r = 10; r >= 0; r--) begin
            n_tests++;
            if (loadReady !== 1'b0 || keyRound !== 4'(r) || keyOut !== exp_rk[r]) begin
                n_fail++;
                $display("FAIL lwb_r%0d: loadReady=%b round=%0d key=%h, required 0/%0d/%h",
                         r, loadReady, keyRound, keyOut, r, exp_rk[r]);
            end
            @(negedge clk);
        end
        n_tests++;
        if (keyValid !== 1'b0 || loadReady !== 1'b1) begin
            n_fail++;
            $display("FAIL lwb_idle: keyValid=%b loadReady=%b, required 0/1", keyValid, loadReady);
        end
        @(negedge clk);
        loadValid = 1'b0;
        n_tests++;
        if (keyValid !== 1'b1 || keyRound !== 4'd10 || keyOut !== {128{1'b1}}) begin
            n_fail++;
            $display("FAIL lwb_reload: valid=%b round=%0d key=%h, required 1/10/all-ones",
                     keyValid, keyRound, keyOut);
        end
        for (int i = 0; i < 11; i++) @(negedge clk);
        n_tests++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL lwb_drain: busy=%b, required 0", busy);
        end
    endtask

    task automatic test_async_reset();
        expand(FIPS_KEY);
        keyReady = 1'b1;
        do_load(FIPS_RK10);
        for (int i = 0; i < 4; i++) @(negedge clk);
        n_tests++;
        if (keyRound !== 4'd6) begin
            n_fail++;
            $display("FAIL ar_round6: round=%0d, required 6", keyRound);
        end
        #2;
        rst = 1'b1;
        #1;
        n_tests++;
        if ({keyValid, busy, loadReady} !== 3'b001 || keyOut !== '0) begin
            n_fail++;
            $display("FAIL ar_immediate: valid/busy/ready=%b keyOut=%h, required 001/0",
                     {keyValid, busy, loadReady}, keyOut);
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        n_tests++;
        if (keyValid !== 1'b0) begin
            n_fail++;
            $display("FAIL ar_no_keys: keyValid=%b, required 0", keyValid);
        end
        do_load(FIPS_RK10);
        n_tests++;
        if (keyValid !== 1'b1 || keyRound !== 4'd10 || keyOut !== FIPS_RK10) begin
            n_fail++;
            $display("FAIL ar_restart: valid=%b round=%0d key=%h, required 1/10/%h",
                     keyValid, keyRound, keyOut, FIPS_RK10);
        end
        for (int i = 0; i < 11; i++) @(negedge clk);
        n_tests++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL ar_drain: busy=%b, required 0", busy);
        end
    endtask

    task automatic test_round_trip();
        logic [127:0] key;
        keyReady = 1'b1;
        for (int t = 0; t < 100; t++) begin
            key = {$urandom, $urandom, $urandom, $urandom};
            expand(key);
            do_load(exp_rk[10]);
            for (int r = 10; r >= 0; r--) begin
                n_tests++;
                if (keyValid !== 1'b1 || keyRound !== 4'(r) || keyOut !== exp_rk[r]) begin
                    n_fail++;
                    $display("FAIL rt%0d_r%0d: valid=%b round=%0d key=%h, required 1/%0d/%h",
                             t, r, keyValid, keyRound, keyOut, r, exp_rk[r]);
                end
                @(negedge clk);
            end
            n_tests++;
            if (busy !== 1'b0) begin
                n_fail++;
                $display("FAIL rt%0d_done: busy=%b, required 0", t, busy);
            end
        end
    endtask

    initial begin
        n_tests   = 0;
        n_fail    = 0;
        rst       = 1'b1;
        loadValid = 1'b0;
        keyIn     = '0;
        keyReady  = 1'b0;
        build_sbox();
        test_reset();
        test_fips_walk();
        test_backpressure();
        test_load_while_busy();
        test_async_reset();
        test_round_trip();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/inv_key_schedule.md
Name: inv_key_schedule

Overview:
- Iterative inverse AES-128 key expansion: the reverse direction of the forward round-key generator.
- Accepts the final (round-NUM_ROUNDS) round key and emits the round keys NUM_ROUNDS down to 0, one per accepted handshake.
- Feeds the decryption datapath, which consumes round keys in reverse order, without storing the whole expanded schedule.

Parameters:
- NUM_ROUNDS, 10, number of rounds; AES-128 only, so any other value is unsupported.
- LAST_RCON, 8'h36, rcon byte used to generate round key NUM_ROUNDS.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- loadValid  input  1  keyIn is valid.
- loadReady  output  1  block is able to accept a new key (high only in IDLE).
- keyIn  input  128  round-NUM_ROUNDS key, column w0 in bits [127:96].
- keyOut  output  128  current round key.
- keyRound  output  4  round index of keyOut (NUM_ROUNDS..0).
- keyValid  output  1  keyOut/keyRound are valid.
- keyReady  input  1  consumer accepts keyOut this cycle.
- busy  output  1  high while not IDLE.

Behaviour:
- Reset (async, any state): state=IDLE, keyOut=0, keyRound=0, rconReg=0, keyValid=0, busy=0, loadReady=1.
- States: IDLE and RUN.
- IDLE:
  - loadReady=1, keyValid=0.
  - On loadValid: keyOut<=keyIn, keyRound<=NUM_ROUNDS, rconReg<=LAST_RCON, go to RUN.
  - keyValid is high the cycle after the load, so load-to-first-key latency is 1 cycle.
- RUN:
  - keyValid=1, loadReady=0, busy=1.
  - keyOut, keyRound and rconReg hold stable while keyReady=0 (backpressure, unlimited duration).
  - On keyValid&&keyReady with keyRound!=0: keyOut<=prevKey(keyOut,rconReg), keyRound<=keyRound-1, rconReg<=invXtime(rconReg). Stay in RUN.
  - On keyValid&&keyReady with keyRound==0: go to IDLE. keyOut and keyRound hold their last values, but keyValid drops.
- prevKey, with current columns w0..w3 and results p0..p3:
  - p3=w3^w2.
  - p2=w2^w1.
  - p1=w1^w0.
  - p0=w0^SubWord(RotWord(p3))^{rcon,24'h0}.
  - RotWord rotates left by one byte.
  - SubWord applies the standard AES S-box to each byte.
- invXtime(x) = x[0] ? ((x^9'h11b)>>1) : (x>>1), 8-bit result.
  - Sequence produced: 36,1b,80,40,20,10,08,04,02,01.
  - rconReg always equals the rcon that produced the current keyRound.
- Throughput: one key per cycle when keyReady is held high. NUM_ROUNDS+1 keys occupy NUM_ROUNDS+1 consecutive valid cycles.
- loadValid in RUN is ignored; no queuing, and the current key sequence is not disturbed.
- A load in the same cycle as the final handshake is ignored. A new load is accepted in the next IDLE cycle.
- Reset mid-RUN aborts immediately to IDLE; no further keys are emitted.
- The next-key logic is a single-cycle combinational path: 4 S-box lookups plus XORs. No pipelining.

Decomposition:
- Shared package, aes_pkg:
  - AES_NK=4 and NUM_ROUNDS_128=10.
  - The rcon byte table (01,02,04,08,10,20,40,80,1b,36).
  - The 128-bit key and 32-bit word typedefs.
  - The invXtime function.
- Sub-module sub_word: 32-bit combinational SubWord built from four S-box instances, shared with the forward key schedule. Instantiated once.
- The state machine, the registers and the XOR network stay in inv_key_schedule.

Test Plan:
- FIPS-197 walk: load keyIn=d014f9a8c9ee2589e13f0cc8b6630ca6 with keyReady=1 held.
  - Keys are valid on 11 consecutive cycles.
  - keyRound=10: d014f9a8c9ee2589e13f0cc8b6630ca6.
  - keyRound=9: ac7766f319fadc2128d12941575c006e.
  - keyRound=1: a0fafe1788542cb123a339392a6c7605.
  - keyRound=0: 2b7e151628aed2a6abf7158809cf4f3c.
  - busy=0 in the following cycle.
- Backpressure: same load, keyReady toggled randomly.
  - keyOut and keyRound stable on every cycle where keyValid=1 and keyReady=0.
  - The emitted sequence is identical to the walk.
- Load while busy: assert loadValid with keyIn=all-ones during RUN.
  - loadReady=0 and the sequence is unaffected.
  - After the round-0 handshake, the next loadValid is accepted and keyRound=10 appears 1 cycle later.
- Async reset mid-run: assert rst while keyRound=6, between clock edges.
  - keyValid=0, busy=0, keyOut=0 and loadReady=1 immediately, without waiting for a clock edge.
  - A subsequent load restarts at keyRound=10.
- Round trip: drive random 128-bit cipher keys through the forward generator chain to obtain round key 10, then load that key.
  - Round-0 output equals the original key.
  - Every intermediate key matches the forward chain for 100 random keys.
